vregfile_wb: RTL and testbench

- Writeback-stage consumer of the memory-to-writeback pipeline register outputs.
- Selects the writeback result, either ALU result or memory read data.
- Commits the result into a 16-entry x 128-bit vector register file.
- Serves two combinational read ports to decode, with write-through bypass, and reports commit status/count for debug and hazard logic.

---
 rtl/vregfile_wb.sv | 81 ++++++++
 tb/tb_vregfile_wb.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/vregfile_wb.sv
// rtl/vregfile_wb.sv - writeback-stage vector register file with bypassed read ports
//
// Purpose:
//   Selects the writeback result (ALU result or load data), commits it into a
//   NREGS x DATA_W vector register file, serves two combinational read ports
//   with write-through bypass, and reports commit status and count.
//
// Ports:
//   clk, rst               clock (rising edge), synchronous active-high reset
//   stall_W                suppresses the commit for this cycle
//   regw_W                 register write request
//   regmem_W               1 selects readdata_W, 0 selects ALUrslt_W
//   regScr_W               destination register index
//   ALUrslt_W, readdata_W  candidate writeback values
//   ra1_D, ra2_D           read addresses from decode
//   rd1_D, rd2_D           read data to decode (bypassed)
//   result_W               selected writeback value (combinational)
//   wb_valid               pulse: a commit happened on the last edge
//   wb_addr                index of the last commit
//   wb_count               commits since reset, wraps modulo 2^CNT_W
module vregfile_wb #(
  parameter int DATA_W = 128,
  parameter int NREGS  = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_W,
  input  logic              regw_W,
  input  logic              regmem_W,
  input  logic [ADDR_W-1:0] regScr_W,
  input  logic [DATA_W-1:0] ALUrslt_W,
  input  logic [DATA_W-1:0] readdata_W,
  input  logic [ADDR_W-1:0] ra1_D,
  input  logic [ADDR_W-1:0] ra2_D,
  output logic [DATA_W-1:0] rd1_D,
  output logic [DATA_W-1:0] rd2_D,
  output logic [DATA_W-1:0] result_W,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [CNT_W-1:0]  wb_count
);

  logic [DATA_W-1:0] regs [NREGS];
  logic              we;

  assign result_W = regmem_W ? readdata_W : ALUrslt_W;

  // rst is folded into the write enable so the bypass is also off while the
  // file is being cleared; reads then return stored contents.
  assign we = regw_W & ~stall_W & ~rst;

  // Write-through bypass: a same-cycle commit is visible to decode, which
  // removes the W-to-D hazard without a stall.
  always_comb begin
    rd1_D = regs[ra1_D];
    rd2_D = regs[ra2_D];
    if (we && (ra1_D == regScr_W)) rd1_D = result_W;
    if (we && (ra2_D == regScr_W)) rd2_D = result_W;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_count <= '0;
    end else if (we) begin
      regs[regScr_W] <= result_W;
      wb_valid       <= 1'b1;
      wb_addr        <= regScr_W;
      wb_count       <= wb_count + CNT_W'(1);
    end else begin
      wb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vregfile_wb.sv
// tb/tb_vregfile_wb.sv - self-checking bench for vregfile_wb
module tb_vregfile_wb;

  localparam int DATA_W = 128;
  localparam int NREGS  = 16;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              stall_W = 1'b0;
  logic              regw_W = 1'b0;
  logic              regmem_W = 1'b0;
  logic [ADDR_W-1:0] regScr_W = '0;
  logic [DATA_W-1:0] ALUrslt_W = '0;
  logic [DATA_W-1:0] readdata_W = '0;
  logic [ADDR_W-1:0] ra1_D = '0;
  logic [ADDR_W-1:0] ra2_D = '0;
  logic [DATA_W-1:0] rd1_D, rd2_D, result_W;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [CNT_W-1:0]  wb_count;

  int checks = 0;
  int errors = 0;

  vregfile_wb #(
    .DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .stall_W(stall_W), .regw_W(regw_W),
    .regmem_W(regmem_W), .regScr_W(regScr_W), .ALUrslt_W(ALUrslt_W),
    .readdata_W(readdata_W), .ra1_D(ra1_D), .ra2_D(ra2_D),
    .rd1_D(rd1_D), .rd2_D(rd2_D), .result_W(result_W),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: architectural register contents plus commit status.
  logic [DATA_W-1:0] m_regs [NREGS];
  bit                m_valid;
  int                m_addr;
  int                m_count;
  bit                m_live = 1'b0;

  function automatic logic [DATA_W-1:0] m_result();
    return regmem_W ? readdata_W : ALUrslt_W;
  endfunction

  function automatic bit m_commit();
    return (regw_W === 1'b1) && (stall_W === 1'b0) && (rst === 1'b0);
  endfunction

  function automatic logic [DATA_W-1:0] m_read(input int ra);
    if (m_commit() && ra == int'(regScr_W)) return m_result();
    return m_regs[ra];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
      m_valid = 0;
      m_addr  = 0;
      m_count = 0;
      m_live  = 1'b1;
    end else if (m_commit()) begin
      m_regs[regScr_W] = m_result();
      m_valid = 1;
      m_addr  = int'(regScr_W);
      m_count = (m_count + 1) % (1 << CNT_W);
    end else begin
      m_valid = 0;
    end
  end

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_live) begin
      check("cyc_result", result_W, m_result());
      check("cyc_rd1", rd1_D, m_read(int'(ra1_D)));
      check("cyc_rd2", rd2_D, m_read(int'(ra2_D)));
      check("cyc_valid", DATA_W'(wb_valid), DATA_W'(m_valid));
      check("cyc_addr", DATA_W'(wb_addr), DATA_W'(m_addr));
      check("cyc_count", DATA_W'(wb_count), DATA_W'(m_count));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  logic [DATA_W-1:0] ld;
  int c0;

  initial begin
    ld = 128'hDEADBEEF_01234567_89ABCDEF_0000CAFE;

    // Reset with a competing write request held for three edges.
    #1;
    rst = 1; regw_W = 1; regScr_W = 3; ALUrslt_W = 128'hFFFF;
    repeat (3) step();
    rst = 0; regw_W = 0; ra1_D = 3;
    #1;
    check("rst_rd1", rd1_D, '0);
    check("rst_count", DATA_W'(wb_count), '0);
    check("rst_valid", DATA_W'(wb_valid), '0);

    // ALU writebacks to 3 then 4.
    regw_W = 1; regmem_W = 0; regScr_W = 3; ALUrslt_W = 128'h0000FFFF;
    step();
    check("alu_valid1", DATA_W'(wb_valid), 1);
    check("alu_addr1", DATA_W'(wb_addr), 3);
    regScr_W = 4;
    step();
    check("alu_valid2", DATA_W'(wb_valid), 1);
    check("alu_addr2", DATA_W'(wb_addr), 4);
    regw_W = 0; ra1_D = 3; ra2_D = 4;
    #1;
    check("alu_rd1", rd1_D, 128'h0000FFFF);
    check("alu_rd2", rd2_D, 128'h0000FFFF);
    check("alu_count", DATA_W'(wb_count), 2);
    step();
    check("alu_valid_drop", DATA_W'(wb_valid), 0);

    // Load writeback selects readdata_W.
    regw_W = 1; regmem_W = 1; readdata_W = ld; ALUrslt_W = 128'h1; regScr_W = 7;
    #1;
    check("ld_result", result_W, ld);
    step();
    regw_W = 0; regmem_W = 0; ra1_D = 7;
    #1;
    check("ld_entry7", rd1_D, ld);

    // Bypass, first blocked by stall, then live.
    regw_W = 1; regScr_W = 5; ALUrslt_W = 128'h11;
    step();
    stall_W = 1; ALUrslt_W = 128'hA5; ra1_D = 5; ra2_D = 5;
    #1;
    check("byp_stalled_rd1", rd1_D, 128'h11);
    step();
    regw_W = 0; stall_W = 0;
    #1;
    check("byp_stalled_keep", rd1_D, 128'h11);
    regw_W = 1;
    #1;
    check("byp_rd1", rd1_D, 128'hA5);
    check("byp_rd2", rd2_D, 128'hA5);
    step();
    regw_W = 0;
    #1;
    check("byp_stored", rd1_D, 128'hA5);

    // Stall hold: one commit for a held instruction.
    c0 = int'(wb_count);
    regw_W = 1; regScr_W = 9; ALUrslt_W = 128'h99; stall_W = 1;
    step();
    check("stall_v1", DATA_W'(wb_valid), 0);
    step();
    check("stall_v2", DATA_W'(wb_valid), 0);
    stall_W = 0;
    step();
    check("stall_v3", DATA_W'(wb_valid), 1);
    check("stall_cnt", DATA_W'(wb_count), DATA_W'(c0 + 1));
    regw_W = 0;
    step();
    check("stall_v4", DATA_W'(wb_valid), 0);
    check("stall_cnt_hold", DATA_W'(wb_count), DATA_W'(c0 + 1));

    // Counter wrap: reset, 65535 commits, then one more.
    rst = 1;
    step();
    rst = 0; regw_W = 1;
    for (int i = 0; i < 65535; i++) begin
      regScr_W = ADDR_W'(i); ALUrslt_W = DATA_W'(i + 1);
      step();
    end
    check("wrap_ffff", DATA_W'(wb_count), 128'hFFFF);
    step();
    check("wrap_zero", DATA_W'(wb_count), 0);
    regw_W = 0; ra1_D = 2;
    #1;
    check("pre_rst_entry2", rd1_D, 128'd65523);

    // Reset beats a same-cycle write.
    rst = 1; regw_W = 1; regScr_W = 2; ALUrslt_W = 128'h77;
    step();
    rst = 0; regw_W = 0;
    #1;
    check("rstpri_entry2", rd1_D, '0);
    check("rstpri_count", DATA_W'(wb_count), '0);
    check("rstpri_valid", DATA_W'(wb_valid), '0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
